// File: rtl/mskaes_128bits_ks_ctrl.sv
// Sequencing controller for the masked AES-128 key-schedule datapath.
// Loads the master key, then alternates between presenting a round key to
// the cipher core (EMIT) and running the shared Sbox pipeline (SBOX) until
// round NROUNDS has been handed over. Drives only public control strobes.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for start; key register content not meaningful to core
// EMIT  | round key `round_q` held in key register, offered via rk_valid
// SBOX  | Sbox pipeline filling for next round; capture on last cnt cycle
module mskaes_128bits_ks_ctrl #(
  parameter int NROUNDS  = 10,
  parameter int SBOX_LAT = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       abort,
  output logic       busy,
  output logic       ks_data_in_valid,
  output logic       ks_rcon_rst,
  output logic       ks_rcon_update,
  output logic       key_reg_en,
  output logic       key_sel_init,
  output logic       rnd_req,
  output logic       rk_valid,
  input  logic       rk_ready,
  output logic [3:0] rk_round,
  output logic       rk_last
);

  // A one-cycle Sbox still needs a 1-bit counter so the port widths stay legal.
  localparam int CNT_W = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_SBOX = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SBOX_LAT - 1);
  localparam logic [3:0]       ROUND_LAST = 4'(NROUNDS);

  logic [1:0]       state_q, state_d;
  logic [3:0]       round_q, round_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Next-state and output decode; abort overrides everything at the end.
  always_comb begin
    state_d          = state_q;
    round_d          = round_q;
    cnt_d            = cnt_q;
    start_ready      = 1'b0;
    ks_data_in_valid = 1'b0;
    ks_rcon_rst      = 1'b0;
    ks_rcon_update   = 1'b0;
    key_reg_en       = 1'b0;
    key_sel_init     = 1'b0;
    rnd_req          = 1'b0;
    rk_valid         = 1'b0;
    rk_round         = 4'd0;

    case (state_q)
      S_IDLE: begin
        start_ready = !abort;
        if (start_valid && !abort) begin
          key_reg_en   = 1'b1;
          key_sel_init = 1'b1;
          ks_rcon_rst  = 1'b1;
          round_d      = 4'd0;
          state_d      = S_EMIT;
        end
      end
      S_EMIT: begin
        rk_round = round_q;
        if (!abort) begin
          rk_valid = 1'b1;
          if (rk_ready) begin
            if (round_q == ROUND_LAST) begin
              state_d = S_IDLE;
              round_d = 4'd0;
            end else begin
              state_d = S_SBOX;
              cnt_d   = '0;
            end
          end
        end
      end
      S_SBOX: begin
        if (!abort) begin
          ks_data_in_valid = 1'b1;
          rnd_req          = 1'b1;
          cnt_d            = cnt_q + CNT_W'(1);
          // Pipeline output is ready: capture it and step rcon with it, so
          // the rcon seen by the next round matches the key just captured.
          if (cnt_q == CNT_LAST) begin
            key_reg_en     = 1'b1;
            ks_rcon_update = 1'b1;
            round_d        = round_q + 4'd1;
            cnt_d          = '0;
            state_d        = S_EMIT;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        round_d = 4'd0;
        cnt_d   = '0;
      end
    endcase

    if (abort) begin
      state_d     = S_IDLE;
      round_d     = 4'd0;
      cnt_d       = '0;
      ks_rcon_rst = 1'b1;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign rk_last = rk_valid && (round_q == ROUND_LAST);

  // State and counter registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      round_q <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
    end
  end

  // Structural properties of the strobe decode.
  a_no_load_in_emit : assert property (@(posedge clk) disable iff (!nrst)
    (state_q == S_EMIT) |-> !key_reg_en);
  a_rcon_with_capture : assert property (@(posedge clk) disable iff (!nrst)
    ks_rcon_update |-> (key_reg_en && !key_sel_init));
  a_round_range : assert property (@(posedge clk) disable iff (!nrst)
    rk_round <= ROUND_LAST);
  a_rnd_matches_sbox : assert property (@(posedge clk) disable iff (!nrst)
    ks_data_in_valid == rnd_req);

endmodule

// File: tb/tb_mskaes_128bits_ks_ctrl.sv
module tb_mskaes_128bits_ks_ctrl;
  localparam int N   = 10;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic start_valid = 1'b0, abort = 1'b0, rk_ready = 1'b0;
  logic sw_start = 1'b0;
  logic tie0 = 1'b0, tie1 = 1'b1;

  logic start_ready, busy, div, rrst, rupd, kre, ksi, rnd, rkv, last;
  logic [3:0] rkr;

  logic a_sr, a_busy, a_div, a_rrst, a_rupd, a_kre, a_ksi, a_rnd, a_rkv, a_last;
  logic [3:0] a_rkr;
  logic b_sr, b_busy, b_div, b_rrst, b_rupd, b_kre, b_ksi, b_rnd, b_rkv, b_last;
  logic [3:0] b_rkr;

  always #5 clk = ~clk;

  mskaes_128bits_ks_ctrl #(.NROUNDS(N), .SBOX_LAT(LAT)) dut (
    .clk(clk), .nrst(nrst), .start_valid(start_valid), .start_ready(start_ready),
    .abort(abort), .busy(busy), .ks_data_in_valid(div), .ks_rcon_rst(rrst),
    .ks_rcon_update(rupd), .key_reg_en(kre), .key_sel_init(ksi), .rnd_req(rnd),
    .rk_valid(rkv), .rk_ready(rk_ready), .rk_round(rkr), .rk_last(last));

  mskaes_128bits_ks_ctrl #(.NROUNDS(N), .SBOX_LAT(1)) dut_l1 (
    .clk(clk), .nrst(nrst), .start_valid(sw_start), .start_ready(a_sr),
    .abort(tie0), .busy(a_busy), .ks_data_in_valid(a_div), .ks_rcon_rst(a_rrst),
    .ks_rcon_update(a_rupd), .key_reg_en(a_kre), .key_sel_init(a_ksi), .rnd_req(a_rnd),
    .rk_valid(a_rkv), .rk_ready(tie1), .rk_round(a_rkr), .rk_last(a_last));

  mskaes_128bits_ks_ctrl #(.NROUNDS(N), .SBOX_LAT(6)) dut_l6 (
    .clk(clk), .nrst(nrst), .start_valid(sw_start), .start_ready(b_sr),
    .abort(tie0), .busy(b_busy), .ks_data_in_valid(b_div), .ks_rcon_rst(b_rrst),
    .ks_rcon_update(b_rupd), .key_reg_en(b_kre), .key_sel_init(b_ksi), .rnd_req(b_rnd),
    .rk_valid(b_rkv), .rk_ready(tie1), .rk_round(b_rkr), .rk_last(b_last));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: is a job active, which round, how many Sbox cycles
  // remain before the next round key is captured (0 = key being offered).
  bit m_act = 1'b0;
  int m_rnd = 0, m_left = 0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_act = 1'b0; m_rnd = 0; m_left = 0;
    end else if (abort) begin
      m_act = 1'b0; m_rnd = 0; m_left = 0;
    end else if (!m_act) begin
      if (start_valid) begin m_act = 1'b1; m_rnd = 0; m_left = 0; end
    end else if (m_left == 0) begin
      if (rk_ready) begin
        if (m_rnd == N) begin m_act = 1'b0; m_rnd = 0; end
        else m_left = LAT;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) m_rnd = m_rnd + 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic offering, computing, load, capture;
    logic [13:0] e, a;
    offering  = m_act && (m_left == 0);
    computing = m_act && (m_left > 0) && !abort;
    load      = !m_act && start_valid && !abort;
    capture   = computing && (m_left == 1);
    e = {!m_act && !abort, m_act, computing, abort || load, capture,
         load || capture, load, computing, offering && !abort,
         offering ? 4'(m_rnd) : 4'd0, offering && !abort && (m_rnd == N)};
    a = {start_ready, busy, div, rrst, rupd, kre, ksi, rnd, rkv, rkr, last};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL model_outputs: got %h expected %h (cycle %0d)", a, e, cyc);
    end
  end

  // Event recorders for the hand-computed timing checks.
  int vq[$];
  int t0 = -1, lastc = -1, lastbusy = -1, nupd = 0;
  int q1[$], q6[$];
  int d1 = 0, d6 = 0, ts = -1;
  always @(negedge clk) begin
    if (rkv)  vq.push_back(cyc);
    if (ksi)  t0 = cyc;
    if (rupd) nupd++;
    if (last) lastc = cyc;
    if (busy) lastbusy = cyc;
    if (a_rkv) q1.push_back(cyc);
    if (b_rkv) q6.push_back(cyc);
    if (a_div) d1++;
    if (b_div) d6++;
    if (a_ksi) ts = cyc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic wait_round(input int r, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rkv && int'(rkr) == r) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      tick();
    end
    chk("wait_idle", int'(ok), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int rel;

    // Reset state.
    repeat (3) tick();
    chk("rst_start_ready", int'(start_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_key_reg_en", int'(kre), 0);
    chk("rst_rk_valid", int'(rkv), 0);
    chk("rst_rk_round", int'(rkr), 0);
    @(posedge clk);
    #3 nrst = 1'b1;
    chk("release_key_reg_en", int'(kre), 0);
    #1 chk("release_key_reg_en_late", int'(kre), 0);
    tick();
    chk("idle_key_reg_en", int'(kre), 0);

    // Full run with the consumer always ready.
    rk_ready = 1'b1;
    vq.delete(); nupd = 0; lastc = -1;
    pulse_start();
    repeat (56) tick();
    chk("full_nvalid", vq.size(), 11);
    for (int r = 0; r < 11 && r < vq.size(); r++)
      chk("full_valid_cycle", vq[r] - t0, 1 + 5 * r);
    chk("full_last_cycle", lastc - t0, 51);
    chk("full_rcon_updates", nupd, 10);
    chk("full_busy_drop", lastbusy - t0, 51);

    // Backpressure at round 3.
    pulse_start();
    wait_round(3, 40, ok);
    chk("bp_reach_r3", int'(ok), 1);
    rk_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("bp_valid", int'(rkv), 1);
      chk("bp_round", int'(rkr), 3);
      chk("bp_no_load", int'(kre), 0);
      tick();
    end
    rk_ready = 1'b1;
    rel = cyc;
    tick();
    wait_round(4, 20, ok);
    chk("bp_reach_r4", int'(ok), 1);
    chk("bp_r4_delay", cyc - rel, 5);
    wait_idle(80);

    // Abort at Sbox count 2 of round 5.
    pulse_start();
    wait_round(5, 60, ok);
    chk("ab_reach_r5", int'(ok), 1);
    repeat (3) tick();
    abort = 1'b1;
    #1;
    chk("ab_rcon_rst", int'(rrst), 1);
    chk("ab_no_load", int'(kre), 0);
    chk("ab_no_sbox", int'(div), 0);
    tick();
    abort = 1'b0;
    chk("ab_idle", int'(busy), 0);
    pulse_start();
    chk("ab_restart_valid", int'(rkv), 1);
    chk("ab_restart_round", int'(rkr), 0);
    wait_idle(80);

    // Abort and start together in IDLE.
    tick();
    start_valid = 1'b1;
    abort = 1'b1;
    #1;
    chk("as_start_ready", int'(start_ready), 0);
    chk("as_no_load", int'(kre), 0);
    tick();
    start_valid = 1'b0;
    abort = 1'b0;
    chk("as_stay_idle", int'(busy), 0);

    // Reset in the middle of a run.
    pulse_start();
    repeat (8) tick();
    nrst = 1'b0;
    #1;
    chk("mr_busy", int'(busy), 0);
    chk("mr_start_ready", int'(start_ready), 1);
    tick();
    nrst = 1'b1;
    tick();

    // Sbox latency sweep on the two extra instances.
    q1.delete(); q6.delete(); d1 = 0; d6 = 0;
    sw_start = 1'b1;
    tick();
    sw_start = 1'b0;
    repeat (80) tick();
    chk("l1_nvalid", q1.size(), 11);
    chk("l6_nvalid", q6.size(), 11);
    if (q1.size() > 0) chk("l1_first", q1[0] - ts, 1);
    for (int r = 1; r < q1.size(); r++) chk("l1_spacing", q1[r] - q1[r-1], 2);
    for (int r = 1; r < q6.size(); r++) chk("l6_spacing", q6[r] - q6[r-1], 7);
    chk("l1_sbox_cycles", d1, 10);
    chk("l6_sbox_cycles", d6, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
